// File: rtl/binary_search_ctrl.sv
// rtl/binary_search_ctrl.sv - binary-search initiator for a magnitude comparator
//
// Finds an unknown WIDTH-bit value sitting on the comparator's A input. It
// drives probe values onto B and reads back eq / a_less_b / a_gt_b.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset, released synchronously
//   start     request a new search (ignored while busy)
//   trial     registered probe value, drives comparator B
//   eq        comparator flag: A == trial
//   a_less_b  comparator flag: A <  trial
//   a_gt_b    comparator flag: A >  trial
//   busy      search in progress
//   done      one-cycle pulse when a search terminates
//   found     target located (held until next start)
//   err       illegal flag combination seen (held until next start)
//   result    located value when found=1, else 0
//   probes    number of probes used by the last search

module binary_search_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             eq,
  input  logic             a_less_b,
  input  logic             a_gt_b,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [CW-1:0]    probes
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PROBE  = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam logic [WIDTH:0]   LO_INIT   = '0;
  localparam logic [WIDTH:0]   HI_INIT   = {1'b0, {WIDTH{1'b1}}};
  localparam logic [WIDTH-1:0] TRIAL_INIT = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH:0]   ONE_W     = 1;
  localparam logic [CW-1:0]    ONE_CW    = 1;

  state_t           state;
  logic [WIDTH:0]   lo;
  logic [WIDTH:0]   hi;

  logic             one_hot;
  logic             launch;
  logic [WIDTH:0]   lo_nxt;
  logic [WIDTH:0]   hi_nxt;
  logic             exhausted;
  logic [WIDTH-1:0] trial_nxt;

  // A start is honoured in IDLE and also in the FINISH cycle, so back-to-back
  // searches lose no cycle.
  assign launch  = start && (state != PROBE);

  assign one_hot = ({eq, a_less_b, a_gt_b} == 3'b100) ||
                   ({eq, a_less_b, a_gt_b} == 3'b010) ||
                   ({eq, a_less_b, a_gt_b} == 3'b001);

  always_comb begin
    lo_nxt = lo;
    hi_nxt = hi;
    if (a_gt_b) begin
      lo_nxt = {1'b0, trial} + ONE_W;
    end
    if (a_less_b) begin
      hi_nxt = {1'b0, trial} - ONE_W;
    end
    // Decrementing below zero wraps hi to all-ones in the extended width, which
    // an unsigned lo>hi test cannot see, so that case is caught explicitly.
    exhausted = (a_less_b && (trial == '0)) || (lo_nxt > hi_nxt);
    // Midpoint from a WIDTH+2-bit sum so lo+hi cannot overflow.
    trial_nxt = WIDTH'(({1'b0, lo_nxt} + {1'b0, hi_nxt}) >> 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lo     <= '0;
      hi     <= '0;
      trial  <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      found  <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      probes <= '0;
    end else begin
      done <= 1'b0;
      if (launch) begin
        state  <= PROBE;
        lo     <= LO_INIT;
        hi     <= HI_INIT;
        trial  <= TRIAL_INIT;
        busy   <= 1'b1;
        found  <= 1'b0;
        err    <= 1'b0;
        result <= '0;
        probes <= '0;
      end else begin
        case (state)
          PROBE: begin
            probes <= probes + ONE_CW;
            if (!one_hot) begin
              err   <= 1'b1;
              found <= 1'b0;
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else if (eq) begin
              found  <= 1'b1;
              result <= trial;
              state  <= FINISH;
              busy   <= 1'b0;
              done   <= 1'b1;
            end else if (exhausted) begin
              found <= 1'b0;
              state <= FINISH;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              lo    <= lo_nxt;
              hi    <= hi_nxt;
              trial <= trial_nxt;
            end
          end
          FINISH: begin
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_binary_search_ctrl.sv
// tb/tb_binary_search_ctrl.sv - directed self-checking bench for binary_search_ctrl

module tb_binary_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] trial;
  logic       eq;
  logic       a_less_b;
  logic       a_gt_b;
  logic       busy;
  logic       done;
  logic       found;
  logic       err;
  logic [7:0] result;
  logic [3:0] probes;

  logic [7:0] target;
  int         mode;
  int         n_cmp;
  int         n_bad;
  int         exp_t[$];

  binary_search_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .trial    (trial),
    .eq       (eq),
    .a_less_b (a_less_b),
    .a_gt_b   (a_gt_b),
    .busy     (busy),
    .done     (done),
    .found    (found),
    .err      (err),
    .result   (result),
    .probes   (probes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: 0 honest, 1 a_less_b stuck high, 2 all flags low.
  always_comb begin
    eq       = 1'b0;
    a_less_b = 1'b0;
    a_gt_b   = 1'b0;
    case (mode)
      1: a_less_b = 1'b1;
      2: ;
      default: begin
        eq       = (target == trial);
        a_less_b = (target <  trial);
        a_gt_b   = (target >  trial);
      end
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".trial"},  32'(trial),  0);
    check({tag, ".busy"},   32'(busy),   0);
    check({tag, ".done"},   32'(done),   0);
    check({tag, ".found"},  32'(found),  0);
    check({tag, ".err"},    32'(err),    0);
    check({tag, ".result"}, 32'(result), 0);
    check({tag, ".probes"}, 32'(probes), 0);
  endtask

  // Starts a search and walks the expected trial list in exp_t. start is
  // re-pulsed during probe restart_at (ignored because busy=1).
  task automatic run_search(input string tag, input logic [7:0] tgt,
                            input int exp_found, input int exp_result,
                            input int exp_err, input int restart_at);
    target = tgt;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    for (int i = 0; i < exp_t.size(); i++) begin
      check($sformatf("%s.trial%0d", tag, i), 32'(trial), 32'(exp_t[i]));
      check($sformatf("%s.busy%0d", tag, i), 32'(busy), 1);
      check($sformatf("%s.done%0d", tag, i), 32'(done), 0);
      if (i == restart_at) start = 1'b1;
      tick();
      start = 1'b0;
    end
    check({tag, ".done"},   32'(done),   1);
    check({tag, ".busy"},   32'(busy),   0);
    check({tag, ".found"},  32'(found),  32'(exp_found));
    check({tag, ".result"}, 32'(result), 32'(exp_result));
    check({tag, ".probes"}, 32'(probes), 32'(exp_t.size()));
    check({tag, ".err"},    32'(err),    32'(exp_err));
  endtask

  initial begin
    n_cmp  = 0;
    n_bad  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    mode   = 0;
    target = 8'd0;

    repeat (2) tick();
    check_zero_outputs("reset");
    rst_n = 1'b1;
    tick();
    check("idle.busy", 32'(busy), 0);

    // A=100, with a start re-pulse mid-search that must be ignored.
    exp_t = '{127, 63, 95, 111, 103, 99, 101, 100};
    run_search("a100", 8'd100, 1, 100, 0, 3);
    tick();
    check("a100.done_clear", 32'(done), 0);
    check("a100.found_hold", 32'(found), 1);

    // Upper boundary.
    exp_t = '{127, 191, 223, 239, 247, 251, 253, 254, 255};
    run_search("a255", 8'd255, 1, 255, 0, -1);
    tick();

    // Lower boundary.
    exp_t = '{127, 63, 31, 15, 7, 3, 1, 0};
    run_search("a0", 8'd0, 1, 0, 0, -1);
    tick();

    // Lying comparator: a_less_b stuck high exhausts at trial 0.
    mode  = 1;
    exp_t = '{127, 63, 31, 15, 7, 3, 1, 0};
    run_search("stuck", 8'd100, 0, 0, 0, -1);
    tick();

    // No flags at all on the first probe.
    mode  = 2;
    exp_t = '{127};
    run_search("noflag", 8'd100, 0, 0, 1, -1);
    tick();
    check("noflag.err_hold", 32'(err), 1);

    // A correct search clears err; start held in the done cycle chains a new one.
    mode  = 0;
    exp_t = '{127, 63, 95, 111, 103, 99, 101, 100};
    run_search("clr", 8'd100, 1, 100, 0, -1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("chain.trial",  32'(trial),  127);
    check("chain.busy",   32'(busy),   1);
    check("chain.found",  32'(found),  0);
    check("chain.result", 32'(result), 0);
    begin
      int budget;
      budget = 0;
      while (!done && budget < 20) begin
        tick();
        budget++;
      end
      check("chain.done", 32'(done), 1);
      check("chain.probes", 32'(probes), 8);
    end
    tick();

    // Asynchronous reset after three probes.
    target = 8'd100;
    start  = 1'b1;
    tick();
    start  = 1'b0;
    repeat (3) tick();
    check("pre_rst.busy", 32'(busy), 1);
    check("pre_rst.probes", 32'(probes), 3);
    #2;
    rst_n = 1'b0;
    #1;
    check_zero_outputs("midrst");
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst.busy", 32'(busy), 0);
    exp_t = '{127, 63, 95, 111, 103, 99, 101, 100};
    run_search("post_rst", 8'd100, 1, 100, 0, -1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
